// File: rtl/mjpeg_udp_packer.sv
// Packs a byte-wide MJPEG stream into UDP payloads, each prefixed by a 4-byte frame/packet header.
// Bytes wait in a first-word-fall-through FIFO; i_mjpeg_down flushes the tail of the current frame.
module mjpeg_udp_packer #(
  parameter int PAYLOAD_MAX = 1024,
  parameter int FIFO_AW     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mjpeg_de,
  input  logic [7:0]  i_mjpeg_data,
  input  logic        i_mjpeg_down,
  output logic        o_udp_tx_en,
  output logic [7:0]  o_udp_data,
  output logic [15:0] o_udp_datalen,
  output logic [15:0] o_ipv4_sign,
  input  logic        i_udp_busy,
  input  logic        i_udp_isLoadData,
  output logic        o_overflow,
  output logic [7:0]  o_frame_cnt
);
  localparam int            CW    = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << FIFO_AW);
  localparam logic [CW-1:0] PMAX  = CW'(PAYLOAD_MAX);

  typedef enum logic [2:0] {IDLE, REQ, HDR, PAY, DONE} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [1 << FIFO_AW];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [CW-1:0] frame_left_q, frame_left_d, len_q, len_d, cnt_q, cnt_d;
  logic          end_pending_q, end_pending_d, last_q, last_d, ovf_q, ovf_d;
  logic [1:0]    hidx_q, hidx_d;
  logic [7:0]    frame_id_q, frame_id_d, frame_cnt_q, frame_cnt_d;
  logic [15:0]   pkt_idx_q, pkt_idx_d, sign_q, sign_d, datalen_q, datalen_d;
  logic          wr_en, rd_en;

  assign count = wr_ptr_q - rd_ptr_q;
  assign wr_en = i_mjpeg_de && (count != DEPTH);
  assign rd_en = (state_q == PAY) && i_udp_isLoadData;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= i_mjpeg_data;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q + CW'(wr_en);
    rd_ptr_d      = rd_ptr_q + CW'(rd_en);
    frame_left_d  = frame_left_q;
    end_pending_d = end_pending_q;
    len_d         = len_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    hidx_d        = hidx_q;
    frame_id_d    = frame_id_q;
    frame_cnt_d   = frame_cnt_q;
    pkt_idx_d     = pkt_idx_q;
    sign_d        = sign_q;
    datalen_d     = datalen_q;
    ovf_d         = ovf_q | (i_mjpeg_de && !wr_en);
    o_udp_tx_en   = 1'b0;
    o_udp_data    = 8'h00;

    // frame_left tracks only the ended frame's bytes, so later writes never join its packets
    if (end_pending_q && rd_en) frame_left_d = frame_left_q - CW'(1);
    if (i_mjpeg_down) begin
      if (end_pending_q) begin
        ovf_d = 1'b1;
      end else begin
        end_pending_d = 1'b1;
        frame_left_d  = count + CW'(wr_en) - CW'(rd_en);
      end
    end

    case (state_q)
      IDLE: begin
        if (end_pending_q) begin
          len_d     = (frame_left_q > PMAX) ? PMAX : frame_left_q;
          last_d    = (frame_left_q <= PMAX);
          datalen_d = 16'(len_d) + 16'd4;
          state_d   = REQ;
        end else if (count >= PMAX) begin
          len_d     = PMAX;
          last_d    = 1'b0;
          datalen_d = 16'(PMAX) + 16'd4;
          state_d   = REQ;
        end
      end
      REQ: begin
        o_udp_tx_en = 1'b1;
        if (!i_udp_busy) begin
          hidx_d  = 2'd0;
          state_d = HDR;
        end
      end
      HDR: begin
        case (hidx_q)
          2'd0:    o_udp_data = frame_id_q;
          2'd1:    o_udp_data = pkt_idx_q[15:8];
          2'd2:    o_udp_data = pkt_idx_q[7:0];
          default: o_udp_data = {6'd0, ovf_q, last_q};
        endcase
        if (i_udp_isLoadData) begin
          if (hidx_q == 2'd3) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? DONE : PAY;
          end else begin
            hidx_d = hidx_q + 2'd1;
          end
        end
      end
      PAY: begin
        o_udp_data = mem[rd_ptr_q[FIFO_AW-1:0]];
        if (i_udp_isLoadData) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == len_q - CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        sign_d    = sign_q + 16'd1;
        pkt_idx_d = pkt_idx_q + 16'd1;
        if (last_q) begin
          end_pending_d = 1'b0;
          pkt_idx_d     = 16'd0;
          frame_id_d    = frame_id_q + 8'd1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_left_q  <= '0;
      end_pending_q <= 1'b0;
      len_q         <= '0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      hidx_q        <= 2'd0;
      frame_id_q    <= 8'd0;
      frame_cnt_q   <= 8'd0;
      pkt_idx_q     <= 16'd0;
      sign_q        <= 16'd0;
      datalen_q     <= 16'd0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_left_q  <= frame_left_d;
      end_pending_q <= end_pending_d;
      len_q         <= len_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      hidx_q        <= hidx_d;
      frame_id_q    <= frame_id_d;
      frame_cnt_q   <= frame_cnt_d;
      pkt_idx_q     <= pkt_idx_d;
      sign_q        <= sign_d;
      datalen_q     <= datalen_d;
      ovf_q         <= ovf_d;
    end
  end

  assign o_udp_datalen = datalen_q;
  assign o_ipv4_sign   = sign_q;
  assign o_overflow    = ovf_q;
  assign o_frame_cnt   = frame_cnt_q;
endmodule

// File: doc/mjpeg_udp_packer.md
MJPEG_UDP_PACKER -- requirements
Module: mjpeg_udp_packer

Interface
REQ-001 SHALL have parameter PAYLOAD_MAX, default 1024, meaning the maximum JPEG payload bytes per UDP packet (power of two, 64..1024).
REQ-002 SHALL have parameter FIFO_AW, default 11, meaning the byte FIFO address width (depth 2^FIFO_AW, at least 2*PAYLOAD_MAX).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic; the MJPEG and UDP sides both run on clk.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port i_mjpeg_de, input, 1, meaning the JPEG byte is valid this cycle.
REQ-006 SHALL have port i_mjpeg_data, input, 8, meaning the JPEG stream byte.
REQ-007 SHALL have port i_mjpeg_down, input, 1, a one-cycle pulse marking end of the current JPEG frame.
REQ-008 SHALL have port o_udp_tx_en, output, 1, a packet send request.
REQ-009 SHALL have port o_udp_data, output, 8, the current packet byte.
REQ-010 SHALL have port o_udp_datalen, output, 16, the UDP payload length in bytes (header plus JPEG bytes).
REQ-011 SHALL have port o_ipv4_sign, output, 16, the IPv4 identification of the current packet.
REQ-012 SHALL have port i_udp_busy, input, 1, meaning the UDP transmitter is occupied.
REQ-013 SHALL have port i_udp_isLoadData, input, 1, meaning the transmitter consumes o_udp_data this cycle.
REQ-014 SHALL have port o_overflow, output, 1, a sticky flag set when a byte is dropped because the FIFO is full.
REQ-015 SHALL have port o_frame_cnt, output, 8, the count of frames whose last packet has been sent.

Function
REQ-016 SHALL write i_mjpeg_data into the byte FIFO on every cycle with i_mjpeg_de=1 and the FIFO not full; when the FIFO is full, the byte SHALL be dropped and o_overflow set.
REQ-017 SHALL, on i_mjpeg_down, latch frame_left equal to the FIFO occupancy (including any byte written in the same cycle) and set end_pending.
REQ-018 SHALL ignore i_mjpeg_down while end_pending is already set and SHALL set o_overflow in that case.
REQ-019 SHALL use the FSM states IDLE, REQ, HDR, PAY and DONE.
REQ-020 SHALL, in IDLE, select a packet when either (a) the occupancy available to the current frame is at least PAYLOAD_MAX, giving len=PAYLOAD_MAX, or (b) end_pending is set, giving len=min(frame_left, PAYLOAD_MAX) with last=1 when frame_left<=PAYLOAD_MAX; it SHALL then go to REQ.
REQ-021 SHALL, when frame_left=0 at end_pending, send a header-only packet with last=1.
REQ-022 SHALL, in REQ, drive o_udp_tx_en=1 while o_udp_datalen=4+len and o_ipv4_sign are held stable; the FSM SHALL enter HDR on the first cycle in which i_udp_busy=0 and o_udp_tx_en=1; tx_en SHALL deassert in the next cycle.
REQ-023 SHALL send a 4-byte big-endian header in this order: frame_id[7:0], pkt_idx[15:8], pkt_idx[7:0], flags (bit0=last, bit1=overflow, others 0).
REQ-024 SHALL present byte k on o_udp_data until a cycle with i_udp_isLoadData=1, then present byte k+1 on the next cycle; the first header byte SHALL be valid on entry to HDR.
REQ-025 SHALL read JPEG bytes in PAY from the FIFO in first-word-fall-through order, one per cycle with isLoadData=1, for exactly len bytes; frame_left SHALL decrement per byte while end_pending is set.
REQ-026 SHALL, in DONE, increment o_ipv4_sign (wrapping 16 bits) and pkt_idx.
REQ-027 SHALL, when last=1, clear end_pending, reset pkt_idx to 0, and increment frame_id and o_frame_cnt (each wrapping 8 bits); it SHALL then return to IDLE.
REQ-028 SHALL count bytes written after i_mjpeg_down toward the next frame only, and SHALL never merge them into the current frame's packets.
REQ-029 SHALL keep o_udp_data at 0 outside HDR and PAY.
REQ-030 SHALL treat isLoadData asserted outside HDR and PAY as having no effect.

Reset
REQ-031 SHALL, while rst=1 at a clk edge, empty the FIFO and set the FSM to IDLE; o_udp_tx_en, o_udp_data, o_udp_datalen, o_ipv4_sign, o_overflow, o_frame_cnt, frame_id, pkt_idx, frame_left and end_pending SHALL all be 0.
REQ-032 SHALL abandon any packet in progress when reset is applied mid-packet, with no further bytes emitted.

Verification
REQ-033 SHALL pass this scenario: 100 bytes 0x00..0x63 then down, idle UDP -> one packet, datalen=104, header 00 00 00 01, payload matches, o_frame_cnt=1.
REQ-034 SHALL pass this scenario: 2500 bytes then down with PAYLOAD_MAX=1024 -> 3 packets of datalen 1028, 1028 and 456; pkt_idx 0, 1, 2; last only on the third; ipv4_sign 0, 1, 2.
REQ-035 SHALL pass this scenario: i_udp_busy=1 for 50 cycles during REQ -> tx_en held, datalen stable, HDR entered the cycle after busy falls.
REQ-036 SHALL pass this scenario: isLoadData toggled 1/0 randomly -> o_udp_data advances only after cycles with isLoadData=1, with no byte lost or repeated.
REQ-037 SHALL pass this scenario: down with an empty FIFO -> a 4-byte packet with flags=0x01.
REQ-038 SHALL pass this scenario: 2049 bytes written with the UDP side stalled -> o_overflow=1, exactly 2048 bytes retained, flags bit1 set in later headers.
